// File: rtl/kpyd_pkg.sv
// kpyd_pkg: shared types, keypad geometry, key map and row helpers
package kpyd_pkg;
  typedef logic [3:0] key_t;
  typedef struct packed {
    logic valid;
    key_t key;
  } cand_t;
  localparam int num_rows_c = 4;
  localparam int num_cols_c = 4;
  localparam key_t keymap_c [num_rows_c][num_cols_c] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };
  function automatic logic [2:0] low_count(input logic [3:0] rows);
    return {2'b0, ~rows[0]} + {2'b0, ~rows[1]} + {2'b0, ~rows[2]} + {2'b0, ~rows[3]};
  endfunction
  function automatic logic [1:0] first_low(input logic [3:0] rows);
    return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/kpyd_debounce.sv
// kpyd_debounce: frame-level debounce producing held level, key code and press strobe
module kpyd_debounce
  import kpyd_pkg::*;
#(
  parameter int debounce_frames_p = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_done,
  input  logic cand_valid,
  input  key_t cand_key,
  output key_t key,
  output logic valid,
  output logic pressed
);
  localparam int sw = $clog2(debounce_frames_p + 1);
  localparam logic [sw-1:0] full_c = sw'(debounce_frames_p);
  logic [sw-1:0] stable, stable_next;
  cand_t prev;
  logic same, accept, drop;
  // compare against last frame's candidate and decide accept/release
  always_comb begin
    same = cand_valid == prev.valid && (!cand_valid || cand_key == prev.key);
    stable_next = !same ? sw'(1) : stable == full_c ? full_c : stable + sw'(1);
    accept = stable_next == full_c && cand_valid && (!pressed || key != cand_key);
    drop = stable_next == full_c && !cand_valid;
  end
  // stable counter, remembered candidate and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      prev <= '0;
      key <= '0;
      valid <= 1'b0;
      pressed <= 1'b0;
    end else begin
      valid <= frame_done && accept;
      if (frame_done) begin
        stable <= stable_next;
        prev <= '{valid: cand_valid, key: cand_key};
        if (accept) begin
          key <= cand_key;
          pressed <= 1'b1;
        end else if (drop) begin
          pressed <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/kpyd_scanner.sv
// kpyd_scanner: 4x4 keypad column scan, frame accumulation and debounced key output
module kpyd_scanner
  import kpyd_pkg::*;
#(
  parameter int scan_cycles_p     = 12000,
  parameter int debounce_frames_p = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] kpyd_row_i,
  output logic [3:0] kpyd_col_o,
  output logic [3:0] key_o,
  output logic       valid_o,
  output logic       pressed_o
);
  localparam int dw = $clog2(scan_cycles_p);
  logic [dw-1:0] dwell;
  logic [1:0] col;
  logic [4:0] hits, hits_sum, hits_next;
  cand_t first, first_next, cand;
  logic sample, frame_done;
  // sample timing, running hit count and the frame candidate including this sample
  always_comb begin
    sample = dwell == dw'(scan_cycles_p - 1);
    frame_done = sample && col == 2'd3;
    hits_sum = hits + {2'b0, low_count(kpyd_row_i)};
    hits_next = hits_sum > 5'd16 ? 5'd16 : hits_sum;
    first_next = first.valid || &kpyd_row_i ? first
               : '{valid: 1'b1, key: keymap_c[first_low(kpyd_row_i)][col]};
    cand = '{valid: hits_next == 5'd1, key: first_next.key};
    kpyd_col_o = ~(4'b0001 << col);
  end
  // column rotation, dwell counting and per-frame accumulation
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dwell <= '0;
      col <= '0;
      hits <= '0;
      first <= '0;
    end else begin
      dwell <= sample ? '0 : dwell + dw'(1);
      if (sample) begin
        col <= col + 2'd1;
        hits <= frame_done ? 5'd0 : hits_next;
        first <= frame_done ? '0 : first_next;
      end
    end
  end
  kpyd_debounce #(.debounce_frames_p(debounce_frames_p)) u_debounce (
    .clk(clk_i),
    .rst(reset_i),
    .frame_done(frame_done),
    .cand_valid(cand.valid),
    .cand_key(cand.key),
    .key(key_o),
    .valid(valid_o),
    .pressed(pressed_o)
  );
endmodule

// File: doc/kpyd_scanner.md
Name: kpyd_scanner

Overview:
- Scans a 4x4 matrix keypad (Pmod KYPD style) by driving one column low at a time and sampling the rows.
- Debounces the result across whole scan frames.
- Emits a 4-bit hex key code with a one-cycle press strobe.
- Sits directly upstream of the hex-to-seven-segment display path in the kpyd2ssd top level; its col output drives kpyd_col_o and its key/valid outputs feed the display register.

Parameters:
- scan_cycles_p, 12000, clock cycles each column is held active (1 ms at 12 MHz); must be >= 2.
- debounce_frames_p, 8, consecutive identical full-scan frames required to accept a press or release; must be >= 1.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- kpyd_row_i  input  4  keypad rows, active-low (pulled up, 0 = key in active column pressed); already synchronized upstream.
- kpyd_col_o  output  4  keypad column drive, active-low, exactly one bit low at all times.
- key_o  output  4  hex code of the last accepted key; holds its value after release.
- valid_o  output  1  one-cycle pulse when a new press is accepted; key_o is valid in the same cycle.
- pressed_o  output  1  level, high while the debounced state is "key held".

Behaviour:
- Reset values: kpyd_col_o=4'b1110 (column 0), key_o=4'h0, valid_o=0, pressed_o=0. Column index, dwell counter, frame accumulator, stable counter and candidate are all cleared. Reset mid-frame discards the partial frame, and scanning restarts at column 0 in the cycle after reset deasserts.
- Column drive: col index c runs 0,1,2,3,0,... and kpyd_col_o = ~(4'b0001 << c).
- Dwell counter counts 0..scan_cycles_p-1 per column. Rows are sampled only on the last dwell cycle, which gives settling time. c advances on the following cycle.
- Key map, row r / column c, stored as code[r][c]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Frame accumulation:
  - Each sample adds the count of low row bits to a 0..16 hit counter (saturating, 5 bits).
  - The first hit (lowest c, then lowest r) is recorded.
  - At frame end (the sample at c=3): candidate = recorded code if hits==1, else NONE. Zero keys and multiple keys both yield NONE.
- Debounce, evaluated once per frame end:
  - If candidate equals the previous frame's candidate, the stable counter increments, saturating at debounce_frames_p. Otherwise the stable counter resets to 1 and the candidate is stored.
  - When stable == debounce_frames_p and candidate is key K:
    - If pressed_o=0, or pressed_o=1 with key_o != K: set key_o=K, pressed_o=1, and pulse valid_o for exactly one cycle. valid_o appears in the cycle after the final-frame sample.
    - Otherwise (same key still held): nothing.
  - When stable == debounce_frames_p and candidate is NONE: pressed_o=0, key_o unchanged, no valid_o.
- Held key: exactly one valid_o per accepted press, regardless of hold time.
- Direct change from key A to key B without an intervening NONE frame: accepted as a new press once B has been stable for debounce_frames_p frames.
- Latency: press-to-valid_o is at most (debounce_frames_p+1) frames plus 1 cycle, where one frame = 4*scan_cycles_p cycles.
- No combinational path from kpyd_row_i to any output; all outputs are registered.

Decomposition:
- Package kpyd_pkg:
  - typedef key_t (logic [3:0]).
  - Constants num_rows_c=4 and num_cols_c=4.
  - Constant key map array keymap_c[4][4].
  - Encoding for NONE: a 1-bit valid flag plus key_t, never an overloaded code.
- One sub-module, kpyd_debounce:
  - Inputs: frame_done, candidate valid and code.
  - Owns the stable counter and the pressed_o/key_o/valid_o logic.
  - Parameterized by debounce_frames_p.
- The scanner proper keeps the column rotation, dwell counter and frame accumulation.

Test Plan (scan_cycles_p=4, debounce_frames_p=3, frame=16 cycles):
- Reset: assert reset_i 2 cycles with rows=4'hF -> kpyd_col_o=4'b1110, key_o=0, valid_o=0, pressed_o=0. Col then steps 1110->1101->1011->0111 every 4 cycles.
- Single press: model key '5' (row1 low only while col1 active) held 5 frames -> exactly one valid_o pulse with key_o=4'h5, no earlier than the end of the 3rd full frame. pressed_o=1 thereafter. Releasing for 3 frames -> pressed_o=0, key_o stays 4'h5.
- Bounce: toggle key 'A' (row0/col3) present/absent on alternate frames for 10 frames -> no valid_o, pressed_o stays 0.
- Two keys: hold '1' until accepted, then add '2' for 4 frames -> pressed_o falls to 0 with no valid_o. Release '2' while keeping '1' for 3 frames -> new valid_o with key_o=4'h1.
- Key change: hold 'D' (row3/col3) until accepted, then switch directly to 'F' (row3/col1) -> second valid_o with key_o=4'hF after 3 stable frames.
- Reset mid-operation: assert reset_i during frame 2 of a '0' press -> all outputs return to reset values next cycle. With '0' still held, valid_o with key_o=4'h0 follows 3 full frames after reset deasserts.
